branch_logic: RTL and testbench
===============================

BRANCH_LOGIC -- requirements
Module: branch_logic

Interface
REQ-001 Parameters: none; opcode encodings are fixed constants, listed in REQ-009.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  5  instruction opcode of the instruction being resolved.
REQ-005 flags  input  2  condition flags; flags[1]=Z (zero/equal), flags[0]=N (negative/less-than).
REQ-006 pc_branch_sel_out  output  1  branch-taken select to PC mux; 1=load branch target, 0=PC+1.
REQ-007 One clock domain; the reset is asynchronous and active-high.

Function
REQ-008 Block SHALL compute a taken bit from opcode and flags each cycle.
REQ-009 Opcode encodings: BEQ=5'b10011, BLT=5'b10100, BGT=5'b10101, BNE=5'b10110.
REQ-010 BEQ taken iff Z=1, N ignored (flags 10,11 -> 1; 00,01 -> 0).
REQ-011 BNE taken iff Z=0, N ignored (flags 00,01 -> 1; 10,11 -> 0).
REQ-012 BLT taken iff N=1, Z ignored (flags 01,11 -> 1; 00,10 -> 0).
REQ-013 BGT taken iff N=0, Z ignored (flags 00,10 -> 1; 01,11 -> 0); equality counts as taken by design.
REQ-014 Any other opcode, including all non-branch opcodes, SHALL yield taken=0.
REQ-015 With X/Z on any opcode bit, taken SHALL be 0 (no X propagation to PC select).
REQ-016 Default build: pc_branch_sel_out is registered; value for inputs sampled at rising edge N appears after edge N and holds until edge N+1 (1-cycle latency).
REQ-017 Input changes between edges SHALL not affect the output until the next rising edge.
REQ-018 Opcode change and flag change in the same cycle SHALL be evaluated together against the new pair; no priority or history.
REQ-019 No internal state beyond the output register; behaviour is memoryless apart from the latency.

Reset
REQ-020 While rst=1, pc_branch_sel_out SHALL be 0 immediately (asynchronous), regardless of clk and inputs.
REQ-021 On rst deassertion, the first rising edge with rst=0 SHALL load the taken bit for the current inputs.
REQ-022 Reset asserted mid-operation SHALL force output 0 within the same cycle; no pending branch survives reset.

Configuration
REQ-023 Macro BRANCH_COMB_OUT_EN: when defined, pc_branch_sel_out SHALL be combinational (zero latency) from opcode/flags, forced to 0 while rst=1; clk is then unused.
REQ-024 When BRANCH_COMB_OUT_EN is undefined, the registered behaviour of REQ-016 applies.
REQ-025 Truth table (REQ-010..REQ-015) SHALL be identical in both builds.

Verification
REQ-026 rst=1 for 5 cycles with opcode=BEQ, flags=10 -> output 0 throughout; release rst -> output 1 after the next rising edge.
REQ-027 opcode=BEQ, sweep flags 10,11,01,00 (2 cycles each) -> 1,1,0,0; opcode=BNE, sweep 01,00,11,10 -> 1,1,0,0.
REQ-028 opcode=BLT, sweep 01,11,10,00 -> 1,1,0,0; opcode=BGT, sweep 00,10,01,11 -> 1,1,0,0.
REQ-029 opcode=5'b00000 and 5'b10111 with all four flag values -> output 0 every cycle.
REQ-030 Output at 1 (BEQ, flags=11), assert rst asynchronously between edges -> output 0 before the next edge.
REQ-031 Latency check: change flags from 10 to 00 under BEQ just after an edge -> output stays 1 until the next edge, then 0 (default build); with BRANCH_COMB_OUT_EN -> output 0 immediately.

Source files
------------

// File: rtl/branch_logic_if.sv
// +----------------------------------------------------------------------------+
// | branch_logic_if : opcode/flags in, PC branch select out                    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface branch_logic_if;
  logic [4:0] opcode;
  logic [1:0] flags;
  logic       pc_branch_sel_out;

  modport master (
    output opcode,
    output flags,
    input  pc_branch_sel_out
  );

  modport slave (
    input  opcode,
    input  flags,
    output pc_branch_sel_out
  );
endinterface

`default_nettype wire

// File: rtl/branch_logic.sv
// +----------------------------------------------------------------------------+
// | branch_logic : resolves BEQ/BLT/BGT/BNE taken bit for the PC select mux    |
// | Optional macro BRANCH_COMB_OUT_EN: zero-latency combinational output.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_logic (
  input  logic                 clk,
  input  logic                 rst,
  branch_logic_if.slave        bus
);

  localparam logic [4:0] c_OP_BEQ = 5'b10011;
  localparam logic [4:0] c_OP_BLT = 5'b10100;
  localparam logic [4:0] c_OP_BGT = 5'b10101;
  localparam logic [4:0] c_OP_BNE = 5'b10110;

  logic w_z;
  logic w_n;
  logic w_taken;

  assign w_z = bus.flags[1];
  assign w_n = bus.flags[0];

  // An opcode carrying X/Z matches no item and falls to the not-taken default.
  always_comb begin
    w_taken = 1'b0;
    case (bus.opcode)
      c_OP_BEQ: w_taken = w_z;
      c_OP_BNE: w_taken = ~w_z;
      c_OP_BLT: w_taken = w_n;
      c_OP_BGT: w_taken = ~w_n;
      default:  w_taken = 1'b0;
    endcase
  end

`ifdef BRANCH_COMB_OUT_EN
  assign bus.pc_branch_sel_out = rst ? 1'b0 : w_taken;
`else
  logic r_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
    end else begin
      r_sel <= w_taken;
    end
  end

  assign bus.pc_branch_sel_out = r_sel;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: directed truth-table sweeps, reset and
// latency behaviour, then randomized traffic against a mask-table reference.
`default_nettype none

module tb_branch_logic;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_logic_if bif ();

  branch_logic u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Taken mask per opcode, bit position = flags value {Z,N}.
  function automatic logic model(input logic [4:0] op, input logic [1:0] fl);
    logic [3:0] mask;
    mask = 4'b0000;
    if (!$isunknown(op)) begin
      if (op == BEQ) mask = 4'b1100;
      if (op == BNE) mask = 4'b0011;
      if (op == BLT) mask = 4'b1010;
      if (op == BGT) mask = 4'b0101;
    end
    return mask[fl];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [1:0] fl);
    @(negedge clk);
    bif.opcode = op;
    bif.flags  = fl;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Each flag value is held two cycles; expected taken bits given MSB-first.
  task automatic sweep(input string tag, input logic [4:0] op,
                       input logic [7:0] fls, input logic [3:0] exps);
    for (int i = 0; i < 4; i++) begin
      drive(op, fls[7-2*i -: 2]);
      for (int c = 0; c < 2; c++) begin
        after_edge();
        check(tag, bif.pc_branch_sel_out, exps[3-i]);
      end
    end
  endtask

  initial begin
    logic [4:0] r_op;
    logic [1:0] r_fl;
    logic [4:0] ops [4];
    logic       exp_now;
    checks   = 0;
    failures = 0;
    ops[0] = BEQ; ops[1] = BLT; ops[2] = BGT; ops[3] = BNE;

    // Reset held with a would-be-taken input
    rst = 1'b1;
    bif.opcode = BEQ;
    bif.flags  = 2'b10;
    #1;
    check("reset_immediate", bif.pc_branch_sel_out, 1'b0);
    for (int i = 0; i < 5; i++) begin
      after_edge();
      check("reset_hold", bif.pc_branch_sel_out, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("reset_release", bif.pc_branch_sel_out, 1'b1);

    sweep("beq_sweep", BEQ, 8'b10_11_01_00, 4'b1100);
    sweep("bne_sweep", BNE, 8'b01_00_11_10, 4'b1100);
    sweep("blt_sweep", BLT, 8'b01_11_10_00, 4'b1100);
    sweep("bgt_sweep", BGT, 8'b00_10_01_11, 4'b1100);
    sweep("op00000",   5'b00000, 8'b00_01_10_11, 4'b0000);
    sweep("op10111",   5'b10111, 8'b00_01_10_11, 4'b0000);

    // Unknown opcode bit: either resolution is a non-branch opcode
    drive(5'b0x000, 2'b00);
    after_edge();
    check("x_opcode", bif.pc_branch_sel_out, 1'b0);

    // Asynchronous reset between edges
    drive(BEQ, 2'b11);
    after_edge();
    check("pre_async_rst", bif.pc_branch_sel_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", bif.pc_branch_sel_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("post_async_rst", bif.pc_branch_sel_out, 1'b1);

    // Latency: flags change just after an edge
    drive(BEQ, 2'b10);
    after_edge();
    check("lat_before", bif.pc_branch_sel_out, 1'b1);
    bif.flags = 2'b00;
    #1;
`ifdef BRANCH_COMB_OUT_EN
    check("lat_midcycle", bif.pc_branch_sel_out, 1'b0);
`else
    check("lat_midcycle", bif.pc_branch_sel_out, 1'b1);
`endif
    after_edge();
    check("lat_after", bif.pc_branch_sel_out, 1'b0);

    // Randomized traffic, opcode and flags changing together
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) r_op = ops[$urandom_range(0, 3)];
      else                           r_op = 5'($urandom);
      r_fl = 2'($urandom);
      drive(r_op, r_fl);
      exp_now = model(r_op, r_fl);
      after_edge();
      check("random", bif.pc_branch_sel_out, exp_now);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
